// File: rtl/seq_magnitude_comparator_if.sv
// Handshake/result bundle for the bit-serial magnitude comparator.
// master drives the request side, slave is the comparator.
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;
  logic [CNT_W-1:0] nbits;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, gt, eq, lt, nbits
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, gt, eq, lt, nbits
  );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator: one bit per clock, stops at the
// first differing bit, unsigned or two's-complement per transaction.
module seq_magnitude_comparator #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1),
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  seq_magnitude_comparator_if.slave   cmp
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] a_q, a_n, b_q, b_n;
  logic             sm_q, sm_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic             busy_q, busy_n, done_q, done_n;
  logic             gt_q, gt_n, eq_q, eq_n, lt_q, lt_n;
  logic [CNT_W-1:0] nbits_q, nbits_n;

  logic bit_a, bit_b, inv;

  assign bit_a = a_q[idx_q];
  assign bit_b = b_q[idx_q];
  // A set sign bit means negative, so the MSB sense flips in signed mode.
  assign inv   = sm_q && (idx_q == IDX_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      nbits_q <= '0;
    end else begin
      state_q <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      sm_q    <= sm_n;
      idx_q   <= idx_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      gt_q    <= gt_n;
      eq_q    <= eq_n;
      lt_q    <= lt_n;
      nbits_q <= nbits_n;
    end
  end

  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    b_n     = b_q;
    sm_n    = sm_q;
    idx_n   = idx_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    gt_n    = gt_q;
    eq_n    = eq_q;
    lt_n    = lt_q;
    nbits_n = nbits_q;
    unique case (state_q)
      IDLE: begin
        // Results hold across a new accept; only done refreshes them.
        if (cmp.start) begin
          a_n     = cmp.a;
          b_n     = cmp.b;
          sm_n    = cmp.signed_mode;
          idx_n   = IDX_W'(WIDTH - 1);
          busy_n  = 1'b1;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (bit_a != bit_b) begin
          gt_n    = inv ? bit_b : bit_a;
          lt_n    = inv ? bit_a : bit_b;
          eq_n    = 1'b0;
          nbits_n = CNT_W'(WIDTH) - CNT_W'(idx_q);
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (idx_q == '0) begin
          gt_n    = 1'b0;
          lt_n    = 1'b0;
          eq_n    = 1'b1;
          nbits_n = CNT_W'(WIDTH);
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          idx_n = idx_q - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign cmp.busy  = busy_q;
  assign cmp.done  = done_q;
  assign cmp.gt    = gt_q;
  assign cmp.eq    = eq_q;
  assign cmp.lt    = lt_q;
  assign cmp.nbits = nbits_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Randomized + directed bench for seq_magnitude_comparator against a
// transaction-level reference (arithmetic compare, leading-difference count).
module tb_seq_magnitude_comparator;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  seq_magnitude_comparator_if #(.WIDTH(W)) itf ();

  seq_magnitude_comparator #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .cmp (itf)
  );

  always #5 clk = ~clk;

  // Reference: relation by plain integer compare, {gt,eq,lt}
  function automatic logic [2:0] ref_rel(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic sm);
    longint sx, sy;
    if (sm) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({1'b0, x});
      sy = longint'({1'b0, y});
    end
    return {sx > sy, sx == sy, sx < sy};
  endfunction

  // Positions examined: up to and including the highest differing bit.
  function automatic int ref_n(input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    n = W;
    for (int i = 0; i < W; i++)
      if (x[i] != y[i]) n = W - i;
    return n;
  endfunction

  // Protocol-level model: a job accepted when idle completes ref_n cycles later.
  logic       m_busy, m_done, m_gt, m_eq, m_lt;
  int         m_nbits, m_cnt, p_n;
  logic [2:0] p_rel;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0;
      m_gt <= 1'b0; m_eq <= 1'b0; m_lt <= 1'b0;
      m_nbits <= 0; m_cnt <= 0; p_n <= 0; p_rel <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy  <= 1'b0;
          m_done  <= 1'b1;
          {m_gt, m_eq, m_lt} <= p_rel;
          m_nbits <= p_n;
        end
      end else if (itf.start) begin
        p_rel  <= ref_rel(itf.a, itf.b, itf.signed_mode);
        p_n    <= ref_n(itf.a, itf.b);
        m_cnt  <= ref_n(itf.a, itf.b);
        m_busy <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every cycle advance goes through here, so all outputs are compared each cycle.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      chk("cyc_busy",  64'(itf.busy),  64'(m_busy));
      chk("cyc_done",  64'(itf.done),  64'(m_done));
      chk("cyc_gt",    64'(itf.gt),    64'(m_gt));
      chk("cyc_eq",    64'(itf.eq),    64'(m_eq));
      chk("cyc_lt",    64'(itf.lt),    64'(m_lt));
      chk("cyc_nbits", 64'(itf.nbits), 64'(m_nbits));
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"},  64'(itf.busy),  0);
    chk({name, "_done"},  64'(itf.done),  0);
    chk({name, "_gt"},    64'(itf.gt),    0);
    chk({name, "_eq"},    64'(itf.eq),    0);
    chk({name, "_lt"},    64'(itf.lt),    0);
    chk({name, "_nbits"}, 64'(itf.nbits), 0);
  endtask

  // Presents a request, passes the accept edge, then scrambles the inputs.
  task automatic start_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic sm);
    itf.start = 1'b1; itf.a = ta; itf.b = tb_v; itf.signed_mode = sm;
    tick();
    itf.start = 1'b0;
    itf.a = W'($urandom); itf.b = W'($urandom); itf.signed_mode = 1'($urandom);
  endtask

  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (!itf.done && k <= W + 2) begin
      tick();
      k++;
    end
    if (!itf.done) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, required within %0d", k, W);
    end
  endtask

  task automatic do_txn(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic sm, input logic [2:0] exp_rel, input int exp_n);
    int k;
    chk({name, "_model_rel"}, 64'(ref_rel(ta, tb_v, sm)), 64'(exp_rel));
    chk({name, "_model_n"},   64'(ref_n(ta, tb_v)),       64'(exp_n));
    start_txn(ta, tb_v, sm);
    wait_done(0, k);
    chk({name, "_lat"},   64'(k), 64'(exp_n));
    chk({name, "_rel"},   64'({itf.gt, itf.eq, itf.lt}), 64'(exp_rel));
    chk({name, "_nbits"}, 64'(itf.nbits), 64'(exp_n));
  endtask

  initial begin
    int k;
    logic [W-1:0] ra, rb;
    logic rs;
    itf.start = 1'b0; itf.signed_mode = 1'b0; itf.a = '0; itf.b = '0;
    rst = 1'b1;
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    do_txn("eq_a5",       8'hA5, 8'hA5, 1'b0, 3'b010, 8);
    do_txn("u_80_7f",     8'h80, 8'h7F, 1'b0, 3'b100, 1);
    do_txn("s_80_7f",     8'h80, 8'h7F, 1'b1, 3'b001, 1);
    do_txn("s_fe_ff",     8'hFE, 8'hFF, 1'b1, 3'b001, 8);
    do_txn("s_7f_80",     8'h7F, 8'h80, 1'b1, 3'b100, 1);

    // start while busy with other operands must be ignored
    start_txn(8'h30, 8'h31, 1'b0);
    itf.start = 1'b1; itf.a = 8'hFF; itf.b = 8'h00;
    tick();
    itf.start = 1'b0;
    wait_done(1, k);
    chk("ignore_lat", 64'(k), 8);
    chk("ignore_rel", 64'({itf.gt, itf.eq, itf.lt}), 64'(3'b001));

    // back-to-back: new request presented in the done cycle
    do_txn("b2b_first", 8'hA5, 8'hA5, 1'b0, 3'b010, 8);
    chk("b2b_in_done", 64'(itf.done), 1);
    do_txn("b2b_second", 8'h01, 8'h02, 1'b0, 3'b001, 7);

    // reset at edge 3 of a scan
    start_txn(8'h5A, 8'h5A, 1'b0);
    tick(); tick();
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_all_zero("midrst");
    tick();
    rst = 1'b0;
    repeat (12) begin
      tick();
      chk("midrst_no_done", 64'(itf.done), 0);
    end

    for (int t = 0; t < 250; t++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      rs = 1'($urandom);
      start_txn(ra, rb, rs);
      wait_done(0, k);
      chk("rnd_lat", 64'(k), 64'(ref_n(ra, rb)));
      chk("rnd_rel", 64'({itf.gt, itf.eq, itf.lt}), 64'(ref_rel(ra, rb, rs)));
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
